// File: rtl/mvm_axis_sequencer.sv
// Descriptor/data FIFOs feeding framed AXI-Stream bursts into an MVM tile, plus response capture.
// Optional response watchdog is compiled in when MVM_SEQ_TIMEOUT_EN is defined.
module mvm_axis_sequencer #(
  parameter int unsigned DATAW       = 512,
  parameter int unsigned RFADDRW     = 9,
  parameter int unsigned AXIS_OPSW   = 2,
  parameter int unsigned MASKW       = 64,
  parameter int unsigned USERW       = 75,
  parameter int unsigned DESCD       = 16,
  parameter int unsigned BEATD       = 64,
  parameter int unsigned LENW        = 6,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [AXIS_OPSW-1:0] desc_op,
  input  logic [RFADDRW-1:0]   desc_addr,
  input  logic [MASKW-1:0]     desc_mask,
  input  logic [LENW-1:0]      desc_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [DATAW-1:0]     data_in,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DATAW-1:0]     m_tdata,
  output logic [USERW-1:0]     m_tuser,
  output logic                 m_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DATAW-1:0]     s_tdata,
  output logic [DATAW-1:0]     resp_data,
  output logic [15:0]          resp_count,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned DescW = MASKW + AXIS_OPSW + RFADDRW + LENW;
  localparam int unsigned DPtrW = $clog2(DESCD);
  localparam int unsigned BPtrW = $clog2(BEATD);

  localparam logic [AXIS_OPSW-1:0] OpInst    = '0;
  localparam logic [AXIS_OPSW-1:0] OpRfWrite = AXIS_OPSW'(3);

  typedef enum logic [1:0] {StIdle, StLoad, StStream} state_t;

  // ---------------- descriptor FIFO ----------------
  logic [DescW-1:0] desc_mem [DESCD];
  logic [DPtrW:0]   desc_wptr_q, desc_rptr_q;
  logic             desc_empty, desc_full, desc_push, desc_pop;
  logic [DescW-1:0] desc_head;

  assign desc_empty = desc_wptr_q == desc_rptr_q;
  assign desc_full  = (desc_wptr_q[DPtrW] != desc_rptr_q[DPtrW]) &&
                      (desc_wptr_q[DPtrW-1:0] == desc_rptr_q[DPtrW-1:0]);
  assign desc_ready = !desc_full;
  assign desc_push  = desc_valid && !desc_full;
  assign desc_head  = desc_mem[desc_rptr_q[DPtrW-1:0]];

  always_ff @(posedge clk) begin
    if (desc_push) begin
      desc_mem[desc_wptr_q[DPtrW-1:0]] <= {desc_mask, desc_op, desc_addr, desc_len};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      desc_wptr_q <= '0;
      desc_rptr_q <= '0;
    end else begin
      if (desc_push) desc_wptr_q <= desc_wptr_q + (DPtrW+1)'(1);
      if (desc_pop)  desc_rptr_q <= desc_rptr_q + (DPtrW+1)'(1);
    end
  end

  logic [LENW-1:0]      hd_len;
  logic [RFADDRW-1:0]   hd_addr;
  logic [AXIS_OPSW-1:0] hd_op;
  logic [MASKW-1:0]     hd_mask;

  assign hd_len  = desc_head[LENW-1:0];
  assign hd_addr = desc_head[LENW +: RFADDRW];
  assign hd_op   = desc_head[LENW+RFADDRW +: AXIS_OPSW];
  assign hd_mask = desc_head[LENW+RFADDRW+AXIS_OPSW +: MASKW];

  // ---------------- data FIFO ----------------
  logic [DATAW-1:0] data_mem [BEATD];
  logic [BPtrW:0]   data_wptr_q, data_rptr_q;
  logic             data_empty, data_full, data_push, data_pop;
  logic [DATAW-1:0] data_head;

  assign data_empty = data_wptr_q == data_rptr_q;
  assign data_full  = (data_wptr_q[BPtrW] != data_rptr_q[BPtrW]) &&
                      (data_wptr_q[BPtrW-1:0] == data_rptr_q[BPtrW-1:0]);
  assign data_ready = !data_full;
  assign data_push  = data_valid && !data_full;
  assign data_head  = data_mem[data_rptr_q[BPtrW-1:0]];

  always_ff @(posedge clk) begin
    if (data_push) begin
      data_mem[data_wptr_q[BPtrW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_wptr_q <= '0;
      data_rptr_q <= '0;
    end else begin
      if (data_push) data_wptr_q <= data_wptr_q + (BPtrW+1)'(1);
      if (data_pop)  data_rptr_q <= data_rptr_q + (BPtrW+1)'(1);
    end
  end

  // ---------------- burst FSM and registered AXIS output stage ----------------
  state_t               state_q, state_d;
  logic [AXIS_OPSW-1:0] op_q, op_d;
  logic [RFADDRW-1:0]   addr_q, addr_d;
  logic [MASKW-1:0]     mask_q, mask_d;
  logic [LENW-1:0]      cnt_q, cnt_d;
  logic                 issued_q, issued_d;
  logic                 tvalid_q, tvalid_d;
  logic [DATAW-1:0]     tdata_q, tdata_d;
  logic [USERW-1:0]     tuser_q, tuser_d;
  logic                 tlast_q, tlast_d;
  logic                 hs, load;

  assign hs = tvalid_q && m_tready;
  // A beat is loaded into the output register whenever it is free (or draining this cycle).
  // Instruction beats never wait for data; they take a word if one is there, else zeros.
  assign load = (state_q != StIdle) && !issued_q && (!tvalid_q || m_tready) &&
                (!data_empty || op_q == OpInst);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    desc_pop = 1'b0;
    data_pop = 1'b0;

    if (hs) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = data_empty ? '0 : data_head;
      tuser_d  = USERW'({mask_q, op_q, addr_q});
      tlast_d  = (cnt_q == '0);
      data_pop = !data_empty;
      if (cnt_q == '0) issued_d = 1'b1;
      else             cnt_d    = cnt_q - LENW'(1);
      if (op_q == OpRfWrite) addr_d = addr_q + RFADDRW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (!desc_empty) begin
          desc_pop = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: state_d = StStream;
      StStream: begin
        if (hs && tlast_q) begin
          // Chain straight into the next burst so only one idle cycle separates them.
          if (!desc_empty) begin
            desc_pop = 1'b1;
            state_d  = StLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (desc_pop) begin
      op_d     = hd_op;
      addr_d   = hd_addr;
      mask_d   = hd_mask;
      cnt_d    = hd_len;
      issued_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      issued_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tuser  = tuser_q;
  assign m_tlast  = tlast_q;
  assign busy     = (state_q != StIdle) || !desc_empty;

  // ---------------- response capture ----------------
  logic             s_tready_q;
  logic [DATAW-1:0] resp_data_q;
  logic [15:0]      resp_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_tready_q   <= 1'b0;
      resp_data_q  <= '0;
      resp_count_q <= '0;
    end else begin
      s_tready_q <= 1'b1;
      if (s_tvalid) begin
        resp_data_q <= s_tdata;
        if (resp_count_q != 16'hFFFF) resp_count_q <= resp_count_q + 16'd1;
      end
    end
  end

  assign s_tready   = s_tready_q;
  assign resp_data  = resp_data_q;
  assign resp_count = resp_count_q;

`ifdef MVM_SEQ_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_nxt;
  logic        wd_active_q, timeout_q;

  assign wd_cnt_nxt = wd_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q    <= '0;
      wd_active_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (hs && tlast_q && tuser_q[RFADDRW +: AXIS_OPSW] == OpInst) begin
      wd_cnt_q    <= '0;
      wd_active_q <= 1'b1;
    end else if (s_tvalid) begin
      wd_active_q <= 1'b0;
    end else if (wd_active_q) begin
      wd_cnt_q <= wd_cnt_nxt;
      // Stop at the limit so the counter cannot wrap and the error stays meaningful.
      if (wd_cnt_nxt == 16'(TIMEOUT_CYC)) begin
        timeout_q   <= 1'b1;
        wd_active_q <= 1'b0;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_axis_sequencer.sv
// Directed bench for mvm_axis_sequencer: framing, backpressure, starvation, wrap, fill and reset.
// Exercises the response watchdog as well when MVM_SEQ_TIMEOUT_EN is defined.
module tb_mvm_axis_sequencer;

  localparam int unsigned DATAW = 512;
  localparam int unsigned USERW = 75;

  logic             clk = 1'b0;
  logic             rst;
  logic             desc_valid;
  logic             desc_ready;
  logic [1:0]       desc_op;
  logic [8:0]       desc_addr;
  logic [63:0]      desc_mask;
  logic [5:0]       desc_len;
  logic             data_valid;
  logic             data_ready;
  logic [DATAW-1:0] data_in;
  logic             m_tvalid;
  logic             m_tready;
  logic [DATAW-1:0] m_tdata;
  logic [USERW-1:0] m_tuser;
  logic             m_tlast;
  logic             s_tvalid;
  logic             s_tready;
  logic [DATAW-1:0] s_tdata;
  logic [DATAW-1:0] resp_data;
  logic [15:0]      resp_count;
  logic             busy;
  logic             timeout_err;

  int checks   = 0;
  int failures = 0;

  mvm_axis_sequencer #(.TIMEOUT_CYC(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_op     (desc_op),
    .desc_addr   (desc_addr),
    .desc_mask   (desc_mask),
    .desc_len    (desc_len),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data_in     (data_in),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .resp_data   (resp_data),
    .resp_count  (resp_count),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATAW-1:0] rep(input logic [7:0] b);
    return {64{b}};
  endfunction

  function automatic logic [USERW-1:0] xuser(input logic [63:0] m, input logic [1:0] op,
                                             input logic [8:0] a);
    return {m, op, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_data(input logic [DATAW-1:0] w);
    data_valid = 1'b1;
    data_in    = w;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic push_desc(input logic [1:0] op, input logic [8:0] a, input logic [63:0] m,
                           input logic [5:0] len);
    desc_valid = 1'b1;
    desc_op    = op;
    desc_addr  = a;
    desc_mask  = m;
    desc_len   = len;
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({m_tvalid, m_tlast, s_tready, busy, timeout_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000",
               {m_tvalid, m_tlast, s_tready, busy, timeout_err});
    end
    checks++;
    if (m_tdata !== '0 || m_tuser !== '0 || resp_data !== '0 || resp_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_values tuser=%h count=%0d want all zero", m_tuser, resp_count);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (s_tready !== 1'b1 || desc_ready !== 1'b1 || data_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release s_tready=%b desc_ready=%b data_ready=%b want 111",
               s_tready, desc_ready, data_ready);
    end
  endtask

  task automatic test_rf_write();
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) push_data(rep(8'(i)));
    desc_valid = 1'b1;
    desc_op    = 2'd3;
    desc_addr  = 9'h001;
    desc_mask  = '1;
    desc_len   = 6'd3;
    tick();
    desc_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (m_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL rf_latency cycle=%0d tvalid=%b want 0", c, m_tvalid);
      end
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== rep(8'(b + 1)) ||
          m_tuser !== xuser('1, 2'd3, 9'(b + 1)) || m_tlast !== (b == 3)) begin
        failures++;
        $display("FAIL rf_beat%0d tvalid=%b tuser=%h tlast=%b want 1 %h %b", b, m_tvalid,
                 m_tuser, m_tlast, xuser('1, 2'd3, 9'(b + 1)), (b == 3));
      end
      tick();
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL rf_after tvalid=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) push_data(rep(8'(i)));
    push_desc(2'd3, 9'h001, '1, 6'd3);
    for (int cyc = 0; cyc < 40 && hs < 4; cyc++) begin
      m_tready = (cyc % 3 == 0);
      if (m_tvalid) begin
        checks++;
        if (m_tdata !== rep(8'(hs + 1)) || m_tuser !== xuser('1, 2'd3, 9'(hs + 1)) ||
            m_tlast !== (hs == 3)) begin
          failures++;
          $display("FAIL bp_beat%0d cyc=%0d tuser=%h tlast=%b want %h %b", hs, cyc, m_tuser,
                   m_tlast, xuser('1, 2'd3, 9'(hs + 1)), (hs == 3));
        end
        if (m_tready) hs++;
      end
      tick();
    end
    checks++;
    if (hs != 4 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_count handshakes=%0d tvalid=%b want 4 0", hs, m_tvalid);
    end
  endtask

  task automatic test_starvation();
    int beats = 0;
    m_tready = 1'b1;
    push_desc(2'd2, 9'h010, 64'h0F, 6'd1);
    tick();
    tick();
    for (int cyc = 0; cyc < 15; cyc++) begin
      data_valid = (cyc == 2 || cyc == 7);
      data_in    = (cyc == 2) ? rep(8'hA1) : rep(8'hA2);
      checks++;
      if (m_tvalid !== (cyc == 4 || cyc == 9)) begin
        failures++;
        $display("FAIL starve_valid cyc=%0d tvalid=%b want %b", cyc, m_tvalid,
                 (cyc == 4 || cyc == 9));
      end
      if (m_tvalid) begin
        checks++;
        if (m_tdata !== ((beats == 0) ? rep(8'hA1) : rep(8'hA2)) || m_tlast !== (beats == 1) ||
            m_tuser !== xuser(64'h0F, 2'd2, 9'h010)) begin
          failures++;
          $display("FAIL starve_beat%0d tuser=%h tlast=%b want %h %b", beats, m_tuser, m_tlast,
                   xuser(64'h0F, 2'd2, 9'h010), (beats == 1));
        end
        beats++;
      end
      tick();
    end
    data_valid = 1'b0;
    checks++;
    if (beats != 2) begin
      failures++;
      $display("FAIL starve_count beats=%0d want 2", beats);
    end
  endtask

  task automatic test_addr_wrap();
    int beats = 0;
    m_tready = 1'b1;
    push_data(rep(8'h05));
    push_data(rep(8'h06));
    push_desc(2'd3, 9'h1FF, 64'h1, 6'd1);
    for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
      if (m_tvalid) begin
        checks++;
        if (m_tuser !== xuser(64'h1, 2'd3, (beats == 0) ? 9'h1FF : 9'h000)) begin
          failures++;
          $display("FAIL wrap_beat%0d tuser=%h want %h", beats, m_tuser,
                   xuser(64'h1, 2'd3, (beats == 0) ? 9'h1FF : 9'h000));
        end
        beats++;
      end
      tick();
    end
    checks++;
    if (beats != 2) begin
      failures++;
      $display("FAIL wrap_count beats=%0d want 2", beats);
    end
    beats = 0;
    push_data(rep(8'h07));
    push_data(rep(8'h08));
    push_desc(2'd2, 9'h055, 64'h2, 6'd1);
    for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
      if (m_tvalid) begin
        checks++;
        if (m_tuser !== xuser(64'h2, 2'd2, 9'h055)) begin
          failures++;
          $display("FAIL const_addr_beat%0d tuser=%h want %h", beats, m_tuser,
                   xuser(64'h2, 2'd2, 9'h055));
        end
        beats++;
      end
      tick();
    end
    checks++;
    if (beats != 2) begin
      failures++;
      $display("FAIL const_addr_count beats=%0d want 2", beats);
    end
  endtask

  task automatic test_long_burst();
    int beats = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 64; i++) push_data(rep(8'(i)));
    checks++;
    if (data_ready !== 1'b0) begin
      failures++;
      $display("FAIL data_full data_ready=%b want 0", data_ready);
    end
    push_desc(2'd1, 9'h020, 64'hDEAD_BEEF_0000_FFFF, 6'h3F);
    for (int cyc = 0; cyc < 200 && beats < 64; cyc++) begin
      if (m_tvalid) begin
        if (m_tdata !== rep(8'(beats)) || m_tlast !== (beats == 63) ||
            m_tuser !== xuser(64'hDEAD_BEEF_0000_FFFF, 2'd1, 9'h020)) begin
          failures++;
          $display("FAIL long_beat%0d tlast=%b tuser=%h want %b %h", beats, m_tlast, m_tuser,
                   (beats == 63), xuser(64'hDEAD_BEEF_0000_FFFF, 2'd1, 9'h020));
        end
        checks++;
        beats++;
      end
      tick();
    end
    checks++;
    if (beats != 64 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL long_count beats=%0d tvalid=%b want 64 0", beats, m_tvalid);
    end
  endtask

  task automatic test_response();
    int beats = 0;
    m_tready = 1'b1;
    push_desc(2'd0, 9'h003, '1, 6'd1);
    for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
      if (m_tvalid) begin
        checks++;
        if (m_tdata !== '0 || m_tuser !== xuser('1, 2'd0, 9'h003) || m_tlast !== (beats == 1)) begin
          failures++;
          $display("FAIL inst_beat%0d tuser=%h tlast=%b want %h %b", beats, m_tuser, m_tlast,
                   xuser('1, 2'd0, 9'h003), (beats == 1));
        end
        beats++;
      end
      tick();
    end
    checks++;
    if (beats != 2) begin
      failures++;
      $display("FAIL inst_count beats=%0d want 2", beats);
    end
    repeat (19) tick();
    checks++;
    if (timeout_err !== 1'b0 || resp_count !== 16'd0) begin
      failures++;
      $display("FAIL resp_pre timeout_err=%b count=%0d want 0 0", timeout_err, resp_count);
    end
    s_tvalid = 1'b1;
    s_tdata  = rep(8'hAB);
    tick();
    s_tvalid = 1'b0;
    checks++;
    if (resp_count !== 16'd1 || resp_data !== rep(8'hAB)) begin
      failures++;
      $display("FAIL resp_first count=%0d data=%h want 1 ab..", resp_count, resp_data[31:0]);
    end
    tick();
    s_tvalid = 1'b1;
    s_tdata  = rep(8'hCD);
    tick();
    s_tvalid = 1'b0;
    checks++;
    if (resp_count !== 16'd2 || resp_data !== rep(8'hCD)) begin
      failures++;
      $display("FAIL resp_second count=%0d data=%h want 2 cd..", resp_count, resp_data[31:0]);
    end
  endtask

`ifdef MVM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int seen = 0;
    m_tready = 1'b1;
    push_desc(2'd0, 9'h000, '1, 6'd0);
    for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
      if (m_tvalid && m_tlast) seen = 1;
      tick();
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("FAIL wd_burst seen=%0d want 1", seen);
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      checks++;
      if (timeout_err !== (k >= 32)) begin
        failures++;
        $display("FAIL wd_cycle%0d timeout_err=%b want %b", k, timeout_err, (k >= 32));
      end
    end
  endtask
`endif

  task automatic test_full_reset();
    int accepted = 0;
    int stray = 0;
    m_tready = 1'b0;
    push_data(rep(8'h77));
    push_desc(2'd2, 9'h000, '1, 6'd3);
    push_data(rep(8'h78));
    tick();
    tick();
    for (int i = 0; i < 40; i++) begin
      if (desc_ready !== 1'b1) break;
      desc_valid = 1'b1;
      desc_op    = 2'd2;
      desc_len   = 6'd0;
      tick();
      accepted++;
    end
    desc_valid = 1'b0;
    checks++;
    if (accepted != 16 || desc_ready !== 1'b0 || busy !== 1'b1 || m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL desc_full accepted=%0d ready=%b busy=%b tvalid=%b want 16 0 1 1", accepted,
               desc_ready, busy, m_tvalid);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || resp_count !== 16'd0 || timeout_err !== 1'b0 ||
        s_tready !== 1'b0 || m_tdata !== '0) begin
      failures++;
      $display("FAIL async_reset tvalid=%b busy=%b count=%0d terr=%b s_tready=%b want 0 0 0 0 0",
               m_tvalid, busy, resp_count, timeout_err, s_tready);
    end
    checks++;
    if (desc_ready !== 1'b1 || data_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flush desc_ready=%b data_ready=%b want 1 1", desc_ready, data_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    m_tready = 1'b1;
    tick();
    // A fresh non-instruction burst must stall: the pre-reset data word is gone.
    push_desc(2'd2, 9'h000, '1, 6'd0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (m_tvalid !== 1'b0) stray++;
      tick();
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL post_reset_stray beats=%0d want 0", stray);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t want completion", $time);
    $fatal(1, "bench did not complete");
  end

  initial begin
    rst        = 1'b0;
    desc_valid = 1'b0;
    desc_op    = '0;
    desc_addr  = '0;
    desc_mask  = '0;
    desc_len   = '0;
    data_valid = 1'b0;
    data_in    = '0;
    m_tready   = 1'b0;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    test_reset();
    test_rf_write();
    test_backpressure();
    test_starvation();
    test_addr_wrap();
    test_long_burst();
    test_response();
`ifdef MVM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_full_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
